// File: rtl/program_loader_pkg.sv
// Shared CPU-side definitions: program memory geometry and the loader state encoding.
// Used by the loader, the program counter and the program memory.
package program_loader_pkg;

  localparam int PM_ADDR_W = 5;
  localparam int PM_DEPTH  = 32;
  localparam int INSTR_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    WRITE,
    CHK,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: assembles 16-bit instructions, writes program memory,
// verifies an XOR checksum and releases the core from reset only after a clean load.
//
// state | meaning
// IDLE  | waiting for load_start, core held in reset
// LEN   | expecting the instruction count byte
// HI    | expecting the high byte of an instruction
// LO    | expecting the low byte of an instruction
// WRITE | one-cycle program memory write, then advance address
// CHK   | expecting the checksum byte
// DONE  | load good, core running until next load_start
// ERR   | load bad (count or checksum), core held in reset
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = PM_ADDR_W,
  parameter int DEPTH  = PM_DEPTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_start_i,
  input  logic               rx_valid_i,
  input  logic [7:0]         rx_data_i,
  output logic               rx_ready_o,
  output logic               pm_we_o,
  output logic [ADDR_W-1:0]  pm_addr_o,
  output logic [INSTR_W-1:0] pm_wdata_o,
  output logic               cpu_run_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int CNT_W = ADDR_W + 1;

  loader_state_t      state_q, state_d;
  logic [CNT_W-1:0]   remaining_q;
  logic [7:0]         csum_q;
  logic [7:0]         hi_q;
  logic               rx_ready_q, pm_we_q, cpu_run_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0]  pm_addr_q;
  logic [INSTR_W-1:0] pm_wdata_q;
  logic               accept;
  logic               len_ok;

  assign accept = rx_valid_i && rx_ready_q;
  assign len_ok = (rx_data_i != 8'd0) && (rx_data_i <= 8'(DEPTH));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: if (load_start_i) state_d = LEN;
      LEN:             if (accept) state_d = len_ok ? HI : ERR;
      HI:              if (accept) state_d = LO;
      LO:              if (accept) state_d = WRITE;
      WRITE:           state_d = (remaining_q != CNT_W'(1)) ? HI : CHK;
      CHK:             if (accept) state_d = (rx_data_i == csum_q) ? DONE : ERR;
      default:         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      csum_q      <= '0;
      hi_q        <= '0;
      rx_ready_q  <= 1'b0;
      pm_we_q     <= 1'b0;
      cpu_run_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pm_addr_q   <= '0;
      pm_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      // Outputs are registered decodes of the next state, so they line up with state_q.
      rx_ready_q <= state_d inside {LEN, HI, LO, CHK};
      pm_we_q    <= (state_d == WRITE);
      busy_q     <= state_d inside {LEN, HI, LO, WRITE, CHK};
      done_q     <= (state_d == DONE);
      err_q      <= (state_d == ERR);
      cpu_run_q  <= (state_d == DONE);
      unique case (state_q)
        IDLE, DONE, ERR: begin
          if (load_start_i) begin
            csum_q    <= '0;
            pm_addr_q <= '0;
          end
        end
        LEN: begin
          if (accept && len_ok) begin
            remaining_q <= CNT_W'(rx_data_i);
            csum_q      <= csum_q ^ rx_data_i;
          end
        end
        HI: begin
          if (accept) begin
            hi_q   <= rx_data_i;
            csum_q <= csum_q ^ rx_data_i;
          end
        end
        LO: begin
          if (accept) begin
            pm_wdata_q <= {hi_q, rx_data_i};
            csum_q     <= csum_q ^ rx_data_i;
          end
        end
        WRITE: begin
          remaining_q <= remaining_q - CNT_W'(1);
          // Saturate at the top address so a full-depth load leaves pm_addr at DEPTH-1.
          if (pm_addr_q != ADDR_W'(DEPTH - 1)) pm_addr_q <= pm_addr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rx_ready_o = rx_ready_q;
  assign pm_we_o    = pm_we_q;
  assign pm_addr_o  = pm_addr_q;
  assign pm_wdata_o = pm_wdata_q;
  assign cpu_run_o  = cpu_run_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: scoreboard of expected memory writes
// plus per-scenario status checks.
module tb_program_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        load_start_i = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_ready_o, pm_we_o, cpu_run_o, busy_o, done_o, err_o;
  logic [4:0]  pm_addr_o;
  logic [15:0] pm_wdata_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         got_q[$];
  logic [15:0] mem [32];
  logic [15:0] frame_w [32];

  always #5 clk_i = ~clk_i;

  program_loader dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_start_i(load_start_i),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .rx_ready_o  (rx_ready_o),
    .pm_we_o     (pm_we_o),
    .pm_addr_o   (pm_addr_o),
    .pm_wdata_o  (pm_wdata_o),
    .cpu_run_o   (cpu_run_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  // Write monitor: pm_we is stable for a whole cycle, so sample it mid-cycle.
  always @(negedge clk_i) begin
    if (pm_we_o) begin
      wr_t w;
      w.a = pm_addr_o;
      w.d = pm_wdata_o;
      got_q.push_back(w);
      mem[pm_addr_o] = pm_wdata_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the byte was accepted, valid still high.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    if (gap) begin
      rx_valid_i = 1'b0;
      @(negedge clk_i);
    end
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    t = 0;
    while (!rx_ready_o && t < 40) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 40) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: rx_ready stayed 0 for byte %h, required 1", b);
    end
    @(negedge clk_i);
  endtask

  // Full frame from frame_w[0..n-1]; chk_mask corrupts the checksum; poke pulses load_start mid-load.
  task automatic send_frame(input int n, input logic [7:0] chk_mask, input bit gap, input bit poke);
    logic [7:0] chk;
    logic [7:0] nb;
    wr_t        w;
    nb = n[7:0];
    chk = nb;
    load_start_i = 1'b1;
    rx_valid_i   = 1'b1;
    rx_data_i    = nb;
    @(negedge clk_i);
    load_start_i = 1'b0;
    checks++;
    if ({busy_o, cpu_run_o, done_o, err_o, rx_ready_o} !== 5'b10001) begin
      errors++;
      $display("FAIL frame_start: {busy,cpu_run,done,err,rx_ready}=%b, required 10001",
               {busy_o, cpu_run_o, done_o, err_o, rx_ready_o});
    end
    send_byte(nb, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (poke && i == 1) begin
        rx_valid_i   = 1'b0;
        load_start_i = 1'b1;
        @(negedge clk_i);
        load_start_i = 1'b0;
      end
      chk = chk ^ frame_w[i][15:8] ^ frame_w[i][7:0];
      w.a = 5'(i);
      w.d = frame_w[i];
      exp_q.push_back(w);
      send_byte(frame_w[i][15:8], gap);
      send_byte(frame_w[i][7:0], gap);
    end
    send_byte(chk ^ chk_mask, gap);
    rx_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h5A;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({rx_ready_o, pm_we_o, pm_addr_o, pm_wdata_o, cpu_run_o, busy_o, done_o, err_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%h wdata=%h run=%b busy=%b done=%b err=%b, required all 0",
               rx_ready_o, pm_we_o, pm_addr_o, pm_wdata_o, cpu_run_o, busy_o, done_o, err_o);
    end
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if (rx_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_consume: rx_ready=%b busy=%b, required 0 0", rx_ready_o, busy_o);
    end
    rx_valid_i = 1'b0;
  endtask

  task automatic test_normal();
    frame_w[0] = 16'h1234;
    frame_w[1] = 16'hABCD;
    send_frame(2, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({done_o, cpu_run_o, err_o, busy_o} !== 4'b1100) begin
      errors++;
      $display("FAIL normal_status: {done,run,err,busy}=%b, required 1100", {done_o, cpu_run_o, err_o, busy_o});
    end
    checks++;
    if (pm_addr_o !== 5'd2) begin
      errors++;
      $display("FAIL normal_addr: pm_addr=%0d, required 2", pm_addr_o);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL normal_wr_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL normal_wr%0d: got %h@%0d, required %h@%0d", i, got_q[i].d, got_q[i].a, exp_q[i].d, exp_q[i].a);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // load_start pulsed during the load must be ignored: writes keep going to addr 1.
  task automatic test_reload();
    frame_w[0] = 16'h0F0F;
    frame_w[1] = 16'hC3A5;
    frame_w[2] = 16'h7E81;
    send_frame(3, 8'h00, 1'b0, 1'b1);
    checks++;
    if ({done_o, cpu_run_o, err_o} !== 3'b110) begin
      errors++;
      $display("FAIL reload_status: {done,run,err}=%b, required 110", {done_o, cpu_run_o, err_o});
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reload_wr_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reload_wr%0d: got %h@%0d, required %h@%0d", i, got_q[i].d, got_q[i].a, exp_q[i].d, exp_q[i].a);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_bad_chk();
    frame_w[0] = 16'h1234;
    frame_w[1] = 16'hABCD;
    // The good checksum is 0x42; masking with 0x03 sends 0x41.
    send_frame(2, 8'h03, 1'b0, 1'b0);
    checks++;
    if ({err_o, done_o, cpu_run_o, busy_o} !== 4'b1000) begin
      errors++;
      $display("FAIL badchk_status: {err,done,run,busy}=%b, required 1000", {err_o, done_o, cpu_run_o, busy_o});
    end
    checks++;
    if (mem[0] !== 16'h1234 || mem[1] !== 16'hABCD) begin
      errors++;
      $display("FAIL badchk_mem: mem0=%h mem1=%h, required 1234 abcd", mem[0], mem[1]);
    end
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL badchk_wr_count: got %0d writes, required 2", got_q.size());
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_bad_count(input logic [7:0] n);
    load_start_i = 1'b1;
    rx_valid_i   = 1'b1;
    rx_data_i    = n;
    @(negedge clk_i);
    load_start_i = 1'b0;
    send_byte(n, 1'b0);
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h12;
    checks++;
    if ({err_o, done_o, cpu_run_o, busy_o, rx_ready_o} !== 5'b10000) begin
      errors++;
      $display("FAIL badcnt_%h_status: {err,done,run,busy,rdy}=%b, required 10000", n,
               {err_o, done_o, cpu_run_o, busy_o, rx_ready_o});
    end
    repeat (4) @(negedge clk_i);
    rx_valid_i = 1'b0;
    checks++;
    if (got_q.size() != 0 || rx_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL badcnt_%h_after: writes=%0d rx_ready=%b, required 0 0", n, got_q.size(), rx_ready_o);
    end
    got_q.delete();
  endtask

  task automatic test_full_depth();
    for (int i = 0; i < 32; i++) frame_w[i] = 16'(i);
    send_frame(32, 8'h00, 1'b1, 1'b0);
    checks++;
    if ({done_o, cpu_run_o, err_o} !== 3'b110 || pm_addr_o !== 5'd31) begin
      errors++;
      $display("FAIL full_status: {done,run,err}=%b pm_addr=%0d, required 110 31", {done_o, cpu_run_o, err_o}, pm_addr_o);
    end
    checks++;
    if (got_q.size() != 32) begin
      errors++;
      $display("FAIL full_wr_count: got %0d writes, required 32", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_wr%0d: got %h@%0d, required %h@%0d", i, got_q[i].d, got_q[i].a, exp_q[i].d, exp_q[i].a);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_mid();
    wr_t w;
    load_start_i = 1'b1;
    rx_valid_i   = 1'b1;
    rx_data_i    = 8'h02;
    @(negedge clk_i);
    load_start_i = 1'b0;
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    rx_valid_i = 1'b0;
    w.a = 5'd0;
    w.d = 16'h1234;
    exp_q.push_back(w);
    rst_ni = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({rx_ready_o, pm_we_o, pm_addr_o, pm_wdata_o, cpu_run_o, busy_o, done_o, err_o} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: rdy=%b we=%b addr=%h wdata=%h run=%b busy=%b done=%b err=%b, required all 0",
               rx_ready_o, pm_we_o, pm_addr_o, pm_wdata_o, cpu_run_o, busy_o, done_o, err_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    frame_w[0] = 16'h5678;
    frame_w[1] = 16'h9ABC;
    send_frame(2, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({done_o, cpu_run_o, err_o} !== 3'b110) begin
      errors++;
      $display("FAIL midreset_reload: {done,run,err}=%b, required 110", {done_o, cpu_run_o, err_o});
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midreset_wr_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_wr%0d: got %h@%0d, required %h@%0d", i, got_q[i].d, got_q[i].a, exp_q[i].d, exp_q[i].a);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    @(negedge clk_i);
    test_reset();
    test_normal();
    test_reload();
    test_bad_chk();
    test_bad_count(8'h00);
    test_bad_count(8'h21);
    test_full_depth();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
